muldiv_seq_ctrl: RTL and testbench
==================================

// Module: muldiv_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU beside the EX stage.
//  - Accepts one operation from EX and holds the pipeline with stall_o while it iterates.
//  - Returns the 64-bit {hi,lo} result for the HI/LO register write.
//  - Replaces the single-cycle 64-bit multiply in the EX arithmetic path.
// PARAMETERS
//  DATA_W   32   operand width; iteration count = DATA_W; counter width = $clog2(DATA_W)+1
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       reset; synchronous, active-high
//  start_i         in   1       EX presents a mul/div op this cycle
//  op_i            in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  opa_i           in   DATA_W  rs operand (multiplicand / dividend)
//  opb_i           in   DATA_W  rt operand (multiplier / divisor)
//  annul_i         in   1       flush: cancel the op in flight or being presented
//  stall_o         out  1       hold IF..EX; combinational
//  done_o          out  1       1-cycle pulse: hi_o/lo_o valid this cycle
//  hi_o            out  DATA_W  product[63:32] / remainder
//  lo_o            out  DATA_W  product[31:0] / quotient
//  div_by_zero_o   out  1       qualifies done_o: divisor was zero
// BEHAVIOUR
//  - States: IDLE, RUN, DONE.
//  - Reset: state=IDLE, counter=0, done_o=0, hi_o=lo_o=0, div_by_zero_o=0. stall_o=0 follows from IDLE.
//  - IDLE, start_i=1 and annul_i=0 (accept cycle):
//    - latch |opa|, |opb| (absolute values only for signed ops) and the result-sign flags;
//    - clear counter; go to RUN.
//    - Exception: DIV/DIVU with opb_i=0 goes straight to DONE with hi=opa_i, lo=all-ones, div_by_zero_o=1.
//  - IDLE, start_i=1 and annul_i=1: ignored; stay in IDLE.
//  - RUN: one iteration per cycle, counter 0..DATA_W-1.
//    - Multiply: shift-add, 2*DATA_W accumulator.
//    - Divide: restoring, 1 quotient bit per cycle.
//    - After the iteration at counter=DATA_W-1, go to DONE.
//  - DONE (one cycle):
//    - done_o=1; hi_o/lo_o hold the sign-corrected result; go to IDLE.
//    - start_i in DONE is ignored. The pipeline advances this cycle and the next op is seen in IDLE.
//  - Sign fix-up (applied on entry to DONE):
//    - product negated if sign(a)^sign(b);
//    - quotient negated if sign(a)^sign(b);
//    - remainder takes the sign of the dividend.
//    - 0x80000000 is handled as unsigned magnitude 2^31. DIV 0x80000000/-1 gives lo=0x80000000, hi=0.
//  - stall_o = (IDLE & start_i & ~annul_i & ~divz) | RUN. It is 0 in DONE.
//  - Latency: accept at cycle 0; RUN cycles 1..DATA_W; done_o at cycle DATA_W+1 (33 for DATA_W=32).
//  - Divide-by-zero: done_o at cycle 1, stall_o=0 throughout.
//  - annul_i=1 in RUN: go to IDLE next cycle; no done_o; hi_o/lo_o keep their previous values.
//  - annul_i in DONE: no effect (result already committed).
//  - rst mid-operation: overrides everything; all outputs take reset values next cycle.
//  - hi_o, lo_o and div_by_zero_o change only on entry to DONE or on reset.
//    div_by_zero_o is cleared on every non-div-by-zero DONE.
// CONFIGURATION
//  FAST_MULT_EN defined:
//   - MULT/MULTU compute the full product with a single DATA_W x DATA_W multiply in the accept cycle.
//   - Sequence: IDLE->DONE. stall_o=1 in the accept cycle only; done_o at cycle 1.
//   - Divides are unchanged.
//  FAST_MULT_EN undefined: multiplies use the iterative RUN path (latency DATA_W+1). No multiplier is inferred.
// TESTING
//  1. DIVU opa=100, opb=7 -> done_o at cycle 33; lo=14, hi=2; stall_o high cycles 0..32.
//  2. DIV opa=0xFFFFFFF9 (-7), opb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//  3. MULT 0xFFFFFFFF x 2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//     MULTU same operands -> hi=1, lo=0xFFFFFFFE.
//     done_o at cycle 33, or cycle 1 with FAST_MULT_EN.
//  4. DIVU opa=5, opb=0 -> done_o at cycle 1, div_by_zero_o=1, hi=5, lo=0xFFFFFFFF, stall_o never high.
//  5. DIV started, annul_i=1 at cycle 10 -> stall_o=0 from cycle 11; no done_o; hi/lo equal prior values.
//  6. rst at cycle 5 of a MULTU -> cycle 6: IDLE, all outputs 0.
//     Also: start_i held through DONE -> exactly one done_o, then a new op accepted in IDLE.

Source files
------------

// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer sitting beside EX.
// Multiplies use a shift-add loop and divides use a restoring loop. Each loop
// runs one bit per cycle on operand magnitudes, and the sign is fixed up when
// the result is committed to hi_o/lo_o.
// Optional feature macro: FAST_MULT_EN. When it is defined, MULT/MULTU finish
// in the accept cycle using one DATA_W x DATA_W multiplier.
module muldiv_seq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic              annul_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              div_by_zero_o
);

  localparam int CNT_W = $clog2(DATA_W) + 32'sd1;
  localparam int ACC_W = DATA_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-32'sd1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 32'sd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's-complement negation of a single-width word.
  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-32'sd1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation of a double-width accumulator.
  function automatic logic [ACC_W-1:0] neg_acc(input logic [ACC_W-1:0] v);
    return ~v + {{(ACC_W-32'sd1){1'b0}}, 1'b1};
  endfunction

  state_t              state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [ACC_W-1:0]    acc_r, acc_nxt_s;
  logic [DATA_W-1:0]   m_r;
  logic                is_div_r, neg_res_r, neg_rem_r;
  logic                done_r, dbz_r, stall_s;
  logic [DATA_W-1:0]   hi_r, lo_r;

  logic                accept_s, divz_s, fast_mul_s, last_s, is_div_in_s;
  logic                neg_a_s, neg_b_s;
  logic [DATA_W-1:0]   mag_a_s, mag_b_s;
  logic [DATA_W:0]     sum_s, shl_s, trial_s;
  logic [ACC_W-1:0]    prod_s;
  logic [DATA_W-1:0]   quot_s, rem_s, fix_hi_s, fix_lo_s;

  assign accept_s    = (state_r == S_IDLE) & start_i & ~annul_i;
  assign is_div_in_s = op_i[1];
  assign divz_s      = op_i[1] & (opb_i == {DATA_W{1'b0}});
  assign neg_a_s     = ~op_i[0] & opa_i[DATA_W-1];
  assign neg_b_s     = ~op_i[0] & opb_i[DATA_W-1];
  assign mag_a_s     = neg_a_s ? neg_w(opa_i) : opa_i;
  assign mag_b_s     = neg_b_s ? neg_w(opb_i) : opb_i;
  assign last_s      = (cnt_r == CNT_LAST);

`ifdef FAST_MULT_EN
  logic [ACC_W-1:0] fast_raw_s, fast_prod_s;
  assign fast_mul_s = ~op_i[1];

  // Single-cycle magnitude product with sign fix-up for the fast multiply path.
  always_comb begin
    fast_raw_s  = ACC_W'(mag_a_s) * ACC_W'(mag_b_s);
    fast_prod_s = (neg_a_s ^ neg_b_s) ? neg_acc(fast_raw_s) : fast_raw_s;
  end
`else
  assign fast_mul_s = 1'b0;
`endif

  // One loop iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    sum_s   = {1'b0, acc_r[ACC_W-1:DATA_W]} + (acc_r[0] ? {1'b0, m_r} : {(DATA_W+1){1'b0}});
    shl_s   = {acc_r[ACC_W-1:DATA_W], acc_r[DATA_W-1]};
    trial_s = shl_s - {1'b0, m_r};
    if (is_div_r) begin
      if (trial_s[DATA_W]) begin
        acc_nxt_s = {shl_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
      end else begin
        acc_nxt_s = {trial_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
      end
    end else begin
      acc_nxt_s = {sum_s, acc_r[DATA_W-1:1]};
    end
  end

  // Sign fix-up of the final iteration's result before it is committed.
  always_comb begin
    prod_s = neg_res_r ? neg_acc(acc_nxt_s) : acc_nxt_s;
    quot_s = neg_res_r ? neg_w(acc_nxt_s[DATA_W-1:0]) : acc_nxt_s[DATA_W-1:0];
    rem_s  = neg_rem_r ? neg_w(acc_nxt_s[ACC_W-1:DATA_W]) : acc_nxt_s[ACC_W-1:DATA_W];
    if (is_div_r) begin
      fix_hi_s = rem_s;
      fix_lo_s = quot_s;
    end else begin
      fix_hi_s = prod_s[ACC_W-1:DATA_W];
      fix_lo_s = prod_s[DATA_W-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a zero divisor or a fast multiply skips RUN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (divz_s || fast_mul_s) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_RUN;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (annul_i) begin
          state_nxt_s = S_IDLE;
        end else if (last_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM output logic: pipeline hold while an accepted op is still iterating.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      S_IDLE:  stall_s = start_i & ~annul_i & ~divz_s;
      S_RUN:   stall_s = 1'b1;
      S_DONE:  stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  // Operand latch on accept, then one accumulator step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= CNT_ZERO;
      acc_r     <= {ACC_W{1'b0}};
      m_r       <= {DATA_W{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (accept_s) begin
      cnt_r     <= CNT_ZERO;
      is_div_r  <= is_div_in_s;
      neg_res_r <= neg_a_s ^ neg_b_s;
      neg_rem_r <= neg_a_s;
      m_r       <= is_div_in_s ? mag_b_s : mag_a_s;
      acc_r     <= {{DATA_W{1'b0}}, (is_div_in_s ? mag_a_s : mag_b_s)};
    end else if ((state_r == S_RUN) && !annul_i) begin
      cnt_r <= cnt_r + CNT_ONE;
      acc_r <= acc_nxt_s;
    end
  end

  // Result registers change only when DONE is entered; done pulses for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r <= 1'b0;
      hi_r   <= {DATA_W{1'b0}};
      lo_r   <= {DATA_W{1'b0}};
      dbz_r  <= 1'b0;
    end else begin
      done_r <= (state_nxt_s == S_DONE);
      if (accept_s && divz_s) begin
        hi_r  <= opa_i;
        lo_r  <= {DATA_W{1'b1}};
        dbz_r <= 1'b1;
`ifdef FAST_MULT_EN
      end else if (accept_s && fast_mul_s) begin
        hi_r  <= fast_prod_s[ACC_W-1:DATA_W];
        lo_r  <= fast_prod_s[DATA_W-1:0];
        dbz_r <= 1'b0;
`endif
      end else if ((state_r == S_RUN) && !annul_i && last_s) begin
        hi_r  <= fix_hi_s;
        lo_r  <= fix_lo_s;
        dbz_r <= 1'b0;
      end
    end
  end

  assign stall_o       = stall_s;
  assign done_o        = done_r;
  assign hi_o          = hi_r;
  assign lo_o          = lo_r;
  assign div_by_zero_o = dbz_r;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed testbench for muldiv_seq_ctrl. A scoreboard queue receives the expected
// {hi,lo,div_by_zero} when an op is driven, and the entry is popped on done_o.
`timescale 1ns/1ps
module tb_muldiv_seq_ctrl;
  localparam int W = 32;
`ifdef FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start_i, annul_i;
  logic [1:0]    op_i;
  logic [W-1:0]  opa_i, opb_i;
  logic          stall_o, done_o, div_by_zero_o;
  logic [W-1:0]  hi_o, lo_o;

  muldiv_seq_ctrl #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .opa_i(opa_i),
    .opb_i(opb_i), .annul_i(annul_i), .stall_o(stall_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o), .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dbz = dbz;
    return e;
  endfunction

  // Reference arithmetic computed in 64-bit integers.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p, q, r;
    exp_t e;
    if (op[0]) begin
      sa = longint'({32'h0, a}); sb = longint'({32'h0, b});
    end else begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
    end
    e.dbz = 1'b0;
    if (!op[1]) begin
      p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0];
    end else if (b == 32'h0) begin
      e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
    end else begin
      q = sa / sb; r = sa % sb; e.hi = r[31:0]; e.lo = q[31:0];
    end
    return e;
  endfunction

  // Drive one op from a negedge and follow it through done_o.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e);
    int   lat, stall_bad, done_cyc;
    bit   dz;
    exp_t got;
    dz = op[1] && (b == 32'h0);
    lat = (dz || (!op[1] && FAST)) ? 1 : W + 1;
    sb_q.push_back(e);
    done_cyc = -1; stall_bad = 0;
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
    for (int cyc = 0; cyc <= W + 4; cyc++) begin
      #1;
      if (stall_o !== ((cyc < lat) && !dz)) stall_bad++;
      if (done_cyc >= 0 && cyc == done_cyc + 1) check({tag, " pulse"}, done_o, 1'b0);
      if (done_o === 1'b1 && done_cyc < 0) begin
        done_cyc = cyc;
        check({tag, " sb depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          got = sb_q.pop_front();
          last_e = got;
          check({tag, " hi"}, hi_o, got.hi);
          check({tag, " lo"}, lo_o, got.lo);
          check({tag, " dbz"}, div_by_zero_o, got.dbz);
        end
      end
      @(posedge clk); #1; start_i = 1'b0;
      @(negedge clk);
      if (done_cyc >= 0 && cyc > done_cyc) break;
    end
    if (done_cyc < 0 && sb_q.size() > 0) void'(sb_q.pop_front());
    check({tag, " latency"}, done_cyc, lat);
    check({tag, " stall"}, stall_bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, n_done, d0, d1;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 2'b00;
    opa_i = 32'h0; opb_i = 32'h0;
    last_e = mk(32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("reset hi", hi_o, 32'h0);
    check("reset lo", lo_o, 32'h0);
    check("reset done", done_o, 1'b0);
    check("reset dbz", div_by_zero_o, 1'b0);
    check("reset stall", stall_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu100_7", 2'b11, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0));
    run_op("div-7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
    run_op("mult-1x2", 2'b00, 32'hFFFF_FFFF, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0));
    run_op("multu-1x2", 2'b01, 32'hFFFF_FFFF, 32'd2, mk(32'h1, 32'hFFFF_FFFE, 1'b0));
    run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'h8000_0000, 1'b0));
    run_op("div7_-2", 2'b10, 32'd7, 32'hFFFF_FFFE, mk(32'h1, 32'hFFFF_FFFD, 1'b0));
    run_op("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, mk(32'h4000_0000, 32'h0, 1'b0));
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h1, 1'b0));
    run_op("divu5_0", 2'b11, 32'd5, 32'd0, mk(32'd5, 32'hFFFF_FFFF, 1'b1));
    run_op("div-3_0", 2'b10, 32'hFFFF_FFFD, 32'd0, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1));
    run_op("divu9_4", 2'b11, 32'd9, 32'd4, mk(32'd1, 32'd2, 1'b0));

    for (int i = 0; i < 8; i++) begin
      rop = 2'(i % 4);
      ra = $urandom;
      rb = (i >= 4) ? 32'($urandom_range(1, 15)) : $urandom;
      if (i == 5) rb = 32'hFFFF_FFF0 | rb;
      run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb));
    end

    // start with annul in IDLE must be ignored.
    start_i = 1'b1; annul_i = 1'b1; op_i = 2'b11; opa_i = 32'd50; opb_i = 32'd3;
    bad = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      if (stall_o !== 1'b0 || done_o !== 1'b0) bad++;
      @(negedge clk);
    end
    start_i = 1'b0; annul_i = 1'b0;
    check("annul idle ignored", bad, 0);

    // DIV annulled at cycle 10: no done, outputs keep prior values.
    start_i = 1'b1; op_i = 2'b10; opa_i = 32'd1000; opb_i = 32'd3;
    bad = 0; n_done = 0;
    for (int cyc = 0; cyc < 46; cyc++) begin
      #1;
      if (cyc == 10) check("annul stall c10", stall_o, 1'b1);
      if (cyc == 11) check("annul stall c11", stall_o, 1'b0);
      if (cyc > 11 && stall_o !== 1'b0) bad++;
      if (done_o === 1'b1) n_done++;
      @(posedge clk); #1;
      start_i = 1'b0;
      if (cyc == 9) annul_i = 1'b1;
      if (cyc == 10) annul_i = 1'b0;
      @(negedge clk);
    end
    check("annul no done", n_done, 0);
    check("annul stall low", bad, 0);
    check("annul hi kept", hi_o, last_e.hi);
    check("annul lo kept", lo_o, last_e.lo);
    check("annul dbz kept", div_by_zero_o, last_e.dbz);

    // rst during cycle 5 of a MULTU: all outputs zero at cycle 6.
    start_i = 1'b1; op_i = 2'b01; opa_i = 32'hFFFF_FFFF; opb_i = 32'd2;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      rst = (cyc == 4);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("rst hi", hi_o, 32'h0);
    check("rst lo", lo_o, 32'h0);
    check("rst done", done_o, 1'b0);
    check("rst dbz", div_by_zero_o, 1'b0);
    check("rst stall", stall_o, 1'b0);
    n_done = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk); #1;
      if (done_o === 1'b1) n_done++;
    end
    check("rst no done", n_done, 0);
    @(negedge clk);

    // start_i held through DONE: one done, then a fresh accept in IDLE.
    sb_q.push_back(mk(32'd2, 32'd14, 1'b0));
    sb_q.push_back(mk(32'd2, 32'd14, 1'b0));
    start_i = 1'b1; op_i = 2'b11; opa_i = 32'd100; opb_i = 32'd7;
    n_done = 0; d0 = -1; d1 = -1;
    for (int cyc = 0; cyc < 72; cyc++) begin
      #1;
      if (cyc == 33) check("held stall done", stall_o, 1'b0);
      if (cyc == 34) check("held stall reaccept", stall_o, 1'b1);
      if (done_o === 1'b1) begin
        n_done++;
        if (d0 < 0) d0 = cyc; else if (d1 < 0) d1 = cyc;
        if (sb_q.size() > 0) begin
          last_e = sb_q.pop_front();
          check("held hi", hi_o, last_e.hi);
          check("held lo", lo_o, last_e.lo);
        end
      end
      @(posedge clk); #1;
      if (cyc == 34) start_i = 1'b0;
      @(negedge clk);
    end
    check("held done count", n_done, 2);
    check("held first done", d0, 33);
    check("held second done", d1, 67);
    check("sb empty at end", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
